// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO that feeds a UART transmitter one frame at a time
module uart_tx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic                              flush_i,
    output logic [DATA_WIDTH-1:0]             tx_data_o,
    output logic                              tx_start_o,
    input  logic                              tx_done_i,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o,
    output logic                              fifo_full_o,
    output logic                              fifo_empty_o,
    output logic                              busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  done_q;
    logic                  push;
    logic                  pop;
    logic                  done_rise;

    assign fifo_count_o = count;
    assign fifo_full_o  = (count == DEPTH_C);
    assign fifo_empty_o = (count == '0);
    assign wr_ready_o   = !fifo_full_o;
    assign busy_o       = (state != IDLE);

    // A flush discards a simultaneous write and blocks the pop for that cycle.
    assign push      = wr_valid_i && wr_ready_o && !flush_i;
    assign pop       = (state == IDLE) && !fifo_empty_o && !flush_i;
    // Only a fresh 0->1 transition ends a frame, so a level left over from a previous frame is ignored.
    assign done_rise = tx_done_i && !done_q;

    // Storage array is not reset; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: pop and pulse start, wait for the done edge, then one idle gap cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= tx_done_i;
            tx_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_o  <= mem[rd_ptr];
                        tx_start_o <= 1'b1;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed vector bench for uart_tx_buffer
module tb_uart_tx_buffer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] wr_data_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic       flush_i;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_done_i;
    logic [4:0] fifo_count_o;
    logic       fifo_full_o;
    logic       fifo_empty_o;
    logic       busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_start  = -1000;
    logic       auto_done = 1'b0;
    logic [7:0] seen [$];

    uart_tx_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_data_i    (wr_data_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .flush_i      (flush_i),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .tx_done_i    (tx_done_i),
        .fifo_count_o (fifo_count_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       fl;
        logic       dn;
        logic       st;
        logic [7:0] dat;
        logic [4:0] cnt;
        logic       bsy;
        logic       ful;
        logic       emp;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic fl, input logic dn,
                                input logic st, input logic [7:0] dat, input logic [4:0] cnt,
                                input logic bsy, input logic ful, input logic emp);
        vec_t v;
        v.wv = wv; v.wd = wd; v.fl = fl; v.dn = dn;
        v.st = st; v.dat = dat; v.cnt = cnt; v.bsy = bsy; v.ful = ful; v.emp = emp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (fifo_empty_o && !busy_o) break;
            step();
        end
        chk(name, {31'd0, (fifo_empty_o && !busy_o)}, 32'd1);
    endtask

    // Transmitter stand-in: a few cycles after each start pulse, raise done for one cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (auto_done && tx_start_o) begin
                repeat (3) @(negedge clk_i);
                tx_done_i = 1'b1;
                @(negedge clk_i);
                tx_done_i = 1'b0;
            end
        end
    end

    // Record every start pulse and require at least 3 cycles between consecutive pulses.
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_start_o) begin
                seen.push_back(tx_data_o);
                chk("start_gap", {31'd0, ((cyc - last_start) >= 3)}, 32'd1);
                last_start = cyc;
            end
        end
    end

    initial begin
        // inputs (wv wd fl dn) then expected outputs (st dat cnt bsy ful emp)
        tbl[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0,  1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'hA5, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 8'h3C, 1'b0, 1'b1,  1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h3C, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 8'h11, 1'b0, 1'b0,  1'b0, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 8'h22, 1'b0, 1'b0,  1'b1, 8'h11, 5'd1, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h11, 5'd1, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 8'h33, 1'b1, 1'b0,  1'b0, 8'h11, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h11, 5'd0, 1'b1, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h11, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h11, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[18] = mk(1'b1, 8'h44, 1'b0, 1'b0,  1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h11, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h11, 5'd0, 1'b0, 1'b0, 1'b1);

        rst_i      = 1'b1;
        wr_data_i  = 8'h00;
        wr_valid_i = 1'b0;
        flush_i    = 1'b0;
        tx_done_i  = 1'b0;
        step();
        step();
        chk("reset_outputs",
            {17'd0, tx_start_o, tx_data_o, fifo_count_o, fifo_empty_o, fifo_full_o, wr_ready_o, busy_o},
            {17'd0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        rst_i = 1'b0;

        // Table: single byte, stale done, push+pop, flush during frame, flush blocking a pop.
        for (int i = 0; i < 21; i++) begin
            wr_valid_i = tbl[i].wv;
            wr_data_i  = tbl[i].wd;
            flush_i    = tbl[i].fl;
            tx_done_i  = tbl[i].dn;
            step();
            vectors++;
            if ({tx_start_o, tx_data_o, fifo_count_o, busy_o, fifo_full_o, fifo_empty_o} !==
                {tbl[i].st, tbl[i].dat, tbl[i].cnt, tbl[i].bsy, tbl[i].ful, tbl[i].emp}) begin
                miscompares++;
                $display("FAIL row%0d: got st=%b dat=%h cnt=%0d bsy=%b ful=%b emp=%b expected st=%b dat=%h cnt=%0d bsy=%b ful=%b emp=%b",
                         i, tx_start_o, tx_data_o, fifo_count_o, busy_o, fifo_full_o, fifo_empty_o,
                         tbl[i].st, tbl[i].dat, tbl[i].cnt, tbl[i].bsy, tbl[i].ful, tbl[i].emp);
            end
        end
        wr_valid_i = 1'b0;
        flush_i    = 1'b0;
        tx_done_i  = 1'b0;
        step();

        // Burst of 16 with automatic done responses: order preserved, FIFO drains.
        seen.delete();
        auto_done = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'(i);
            step();
        end
        wr_valid_i = 1'b0;
        wait_idle("burst_drain");
        chk("burst_count", seen.size(), 32'd16);
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            chk($sformatf("burst_byte%0d", i), {24'd0, seen[i]}, i + 1);
        end
        chk("burst_empty", {31'd0, fifo_empty_o}, 32'd1);

        // Full: no done responses, 17 writes leave 1 in flight and 16 stored.
        auto_done = 1'b0;
        step();
        seen.delete();
        for (int i = 0; i < 17; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h40 + 8'(i);
            step();
        end
        wr_valid_i = 1'b0;
        chk("full_count", {27'd0, fifo_count_o}, 32'd16);
        chk("full_flags", {30'd0, fifo_full_o, wr_ready_o}, 32'b10);
        wr_valid_i = 1'b1;
        wr_data_i  = 8'hEE;
        step();
        wr_valid_i = 1'b0;
        chk("full_reject", {27'd0, fifo_count_o}, 32'd16);
        tx_done_i = 1'b1;
        step();
        tx_done_i = 1'b0;
        step();
        step();
        chk("full_pop", {22'd0, tx_start_o, tx_data_o, wr_ready_o}, {22'd0, 1'b1, 8'h41, 1'b1});
        chk("full_pop_count", {27'd0, fifo_count_o}, 32'd15);
        auto_done = 1'b1;
        wait_idle("full_drain");
        chk("full_seen_count", seen.size(), 32'd17);
        for (int i = 0; i < 17 && i < seen.size(); i++) begin
            chk($sformatf("full_byte%0d", i), {24'd0, seen[i]}, 32'h40 + i);
        end

        // Flush with a frame in flight and 5 queued; simultaneous write is dropped.
        auto_done = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h60 + 8'(i);
            step();
        end
        chk("flush_pre", {26'd0, fifo_count_o, busy_o}, {26'd0, 5'd5, 1'b1});
        flush_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h77;
        step();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        chk("flush_post", {17'd0, fifo_count_o, fifo_empty_o, busy_o, tx_data_o},
            {17'd0, 5'd0, 1'b1, 1'b1, 8'h60});
        seen.delete();
        tx_done_i = 1'b1;
        step();
        tx_done_i = 1'b0;
        step();
        chk("flush_frame_done", {31'd0, busy_o}, 32'd0);
        repeat (8) step();
        chk("flush_no_start", seen.size(), 32'd0);

        // Reset mid-frame with 3 entries queued.
        for (int i = 0; i < 4; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h80 + 8'(i);
            step();
        end
        wr_valid_i = 1'b0;
        chk("rst_pre", {26'd0, fifo_count_o, busy_o}, {26'd0, 5'd3, 1'b1});
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async",
            {17'd0, tx_start_o, tx_data_o, fifo_count_o, fifo_empty_o, fifo_full_o, wr_ready_o, busy_o},
            {17'd0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        step();
        step();
        rst_i = 1'b0;
        seen.delete();
        auto_done = 1'b1;
        repeat (10) step();
        chk("rst_no_start", seen.size(), 32'd0);
        chk("rst_idle", {26'd0, fifo_count_o, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
